// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequences the F/D/E/M/W pipeline registers of the 5-stage core.
// It merges hazard-unit stall/flush requests with the M-stage data-memory
// handshake. It produces per-register load enables and bubble clears, tracks
// per-stage valid bits, and keeps cycle/retired/stall performance counters.
module pipe_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic             EnF,
  output logic             EnD,
  output logic             EnE,
  output logic             EnM,
  output logic             EnW,
  output logic             ClrD,
  output logic             ClrE,
  output logic             ClrM,
  output logic             ClrW,
  output logic             ValidD,
  output logic             ValidE,
  output logic             ValidM,
  output logic             ValidW,
  output logic             Retire,
  output logic             BusErr,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstRetCnt,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_MEMWAIT
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [16:0]      wait_inc;
  logic             vd_q, ve_q, vm_q, vw_q;
  logic             vd_d, ve_d, vm_d, vw_d;
  logic [CNT_W-1:0] cyc_q, ret_q, stall_q;
  logic [CNT_W-1:0] cyc_d, ret_d, stall_d;

  logic mem_wait;
  logic run_mode;
  logic freeze;
  logic in_init;
  logic en_f, en_d, en_e, en_m, en_w;
  logic clr_d, clr_e, clr_m, clr_w;
  logic bus_err;

  // Next-state and per-register enable/clear decode.
  // A stalled access that completes or times out falls straight through to the
  // normal RUN decode in the same cycle, so the pipeline restarts without a gap.
  always_comb begin
    mem_wait = vm_q & MemReqM & ~MemReadyM;
    wait_inc = {1'b0, wait_q} + 17'd1;
    state_d  = state_q;
    wait_d   = wait_q;
    run_mode = 1'b0;
    freeze   = 1'b0;
    bus_err  = 1'b0;
    en_f     = 1'b0;
    en_d     = 1'b0;
    en_e     = 1'b0;
    en_m     = 1'b0;
    en_w     = 1'b0;
    clr_d    = 1'b0;
    clr_e    = 1'b0;
    clr_m    = 1'b0;
    clr_w    = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
        en_d    = 1'b1;
        en_e    = 1'b1;
        en_m    = 1'b1;
        en_w    = 1'b1;
        clr_d   = 1'b1;
        clr_e   = 1'b1;
        clr_m   = 1'b1;
        clr_w   = 1'b1;
      end
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_MEMWAIT;
          wait_d  = 16'd1;
          freeze  = 1'b1;
        end else begin
          run_mode = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        if (MemReadyM) begin
          state_d  = ST_RUN;
          wait_d   = '0;
          run_mode = 1'b1;
        end else if (wait_inc >= 17'(TIMEOUT)) begin
          // wait_inc counts the current cycle, so the pulse lands on wait cycle TIMEOUT
          state_d  = ST_RUN;
          wait_d   = '0;
          bus_err  = 1'b1;
          run_mode = 1'b1;
        end else begin
          wait_d = wait_inc[15:0];
          freeze = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (freeze) begin
      en_w  = 1'b1;
      clr_w = 1'b1;
    end
    if (run_mode) begin
      en_f  = ~StallF;
      en_d  = ~StallD | FlushD;
      en_e  = 1'b1;
      en_m  = 1'b1;
      en_w  = 1'b1;
      clr_d = FlushD;
      clr_e = FlushE;
    end
  end

  // Valid-bit and counter next values.
  always_comb begin
    in_init = (state_q == ST_INIT);
    vd_d    = en_d ? ~clr_d : vd_q;
    ve_d    = en_e ? (~clr_e & vd_q) : ve_q;
    vm_d    = en_m ? (~clr_m & ve_q) : vm_q;
    vw_d    = en_w ? (~clr_w & vm_q) : vw_q;
    cyc_d   = cyc_q + {{(CNT_W-1){1'b0}}, ~in_init};
    ret_d   = ret_q + {{(CNT_W-1){1'b0}}, vw_q};
    stall_d = stall_q + {{(CNT_W-1){1'b0}}, (~en_f & ~in_init)};
    if (CntClr) begin
      cyc_d   = '0;
      ret_d   = '0;
      stall_d = '0;
    end
  end

  // State, wait counter, valid bits and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
      vd_q    <= 1'b0;
      ve_q    <= 1'b0;
      vm_q    <= 1'b0;
      vw_q    <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vd_q    <= vd_d;
      ve_q    <= ve_d;
      vm_q    <= vm_d;
      vw_q    <= vw_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  // Reset forces every register to hold off and load a bubble, independent of state.
  always_comb begin
    EnF        = en_f & ~rst;
    EnD        = en_d & ~rst;
    EnE        = en_e & ~rst;
    EnM        = en_m & ~rst;
    EnW        = en_w & ~rst;
    ClrD       = clr_d | rst;
    ClrE       = clr_e | rst;
    ClrM       = clr_m | rst;
    ClrW       = clr_w | rst;
    BusErr     = bus_err & ~rst;
    ValidD     = vd_q;
    ValidE     = ve_q;
    ValidM     = vm_q;
    ValidW     = vw_q;
    Retire     = vw_q;
    CycleCnt   = cyc_q;
    InstRetCnt = ret_q;
    StallCnt   = stall_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random stimulus.
// A reference model tracks instructions as IDs moving through a 4-slot pipe.
module tb_pipe_ctrl;

  localparam int TO = 4;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [4:0]  vld;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic StallF = 0, StallD = 0, FlushD = 0, FlushE = 0;
  logic MemReqM = 0, MemReadyM = 0, CntClr = 0;
  logic EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW;
  logic ValidD, ValidE, ValidM, ValidW, Retire, BusErr;
  logic [31:0] CycleCnt, InstRetCnt, StallCnt;

  pipe_ctrl #(.CNT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
    .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
    .ClrD(ClrD), .ClrE(ClrE), .ClrM(ClrM), .ClrW(ClrW),
    .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
    .Retire(Retire), .BusErr(BusErr),
    .CycleCnt(CycleCnt), .InstRetCnt(InstRetCnt), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: pipe[0..3] = D,E,M,W slot contents (0 = bubble, else instruction ID).
  int          pipe[4];
  int          next_id;
  bit          m_init;
  int          m_wait;
  int unsigned c_cyc, c_ret, c_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs, advance the model.
  task automatic step(input bit r, input bit sf, input bit sd, input bit fd, input bit fe,
                      input bit mq, input bit mr, input bit cc);
    exp_t e;
    bit   en[5];
    bit   clr[5];
    bit   be;
    bit   is_init;
    bit   ret_now;
    int   mode;  // 0 init, 1 run, 2 freeze
    @(posedge clk);
    #1;
    rst = r; StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    MemReqM = mq; MemReadyM = mr; CntClr = cc;
    if (r) begin
      e.ctrl  = 10'b00000_1111_0;
      e.vld   = '0;
      e.cyc   = '0;
      e.ret   = '0;
      e.stall = '0;
      sb_q.push_back(e);
      for (int i = 0; i < 4; i++) pipe[i] = 0;
      m_init = 1; m_wait = 0; c_cyc = 0; c_ret = 0; c_stall = 0;
      return;
    end
    be = 0;
    is_init = m_init;
    if (m_init) mode = 0;
    else if (m_wait > 0) begin
      if (mr) begin mode = 1; m_wait = 0; end
      else if (m_wait + 1 >= TO) begin mode = 1; be = 1; m_wait = 0; end
      else begin mode = 2; m_wait++; end
    end else if (pipe[2] != 0 && mq && !mr) begin
      mode = 2; m_wait = 1;
    end else mode = 1;

    if (mode == 0) begin
      en  = '{0, 1, 1, 1, 1};
      clr = '{0, 1, 1, 1, 1};
    end else if (mode == 2) begin
      en  = '{0, 0, 0, 0, 1};
      clr = '{0, 0, 0, 0, 1};
    end else begin
      en  = '{!sf, (!sd) || fd, 1, 1, 1};
      clr = '{0, fd, fe, 0, 0};
    end
    ret_now = (pipe[3] != 0);
    e.ctrl  = {en[0], en[1], en[2], en[3], en[4], clr[1], clr[2], clr[3], clr[4], be};
    e.vld   = {pipe[0] != 0, pipe[1] != 0, pipe[2] != 0, pipe[3] != 0, ret_now};
    e.cyc   = c_cyc;
    e.ret   = c_ret;
    e.stall = c_stall;
    sb_q.push_back(e);

    for (int s = 3; s >= 0; s--) begin
      if (en[s+1]) begin
        if (clr[s+1]) pipe[s] = 0;
        else if (s == 0) begin next_id++; pipe[s] = next_id; end
        else pipe[s] = pipe[s-1];
      end
    end
    if (cc) begin
      c_cyc = 0; c_ret = 0; c_stall = 0;
    end else begin
      if (!is_init) c_cyc++;
      if (ret_now) c_ret++;
      if (!is_init && !en[0]) c_stall++;
    end
    m_init = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ctrl", {22'd0, EnF, EnD, EnE, EnM, EnW, ClrD, ClrE, ClrM, ClrW, BusErr}, {22'd0, mon_e.ctrl});
      chk("valid", {27'd0, ValidD, ValidE, ValidM, ValidW, Retire}, {27'd0, mon_e.vld});
      chk("CycleCnt", CycleCnt, mon_e.cyc);
      chk("InstRetCnt", InstRetCnt, mon_e.ret);
      chk("StallCnt", StallCnt, mon_e.stall);
    end
  end

  initial begin
    next_id = 0;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    // reset release with no hazards
    idle(24);
    // load-use
    step(0, 1, 1, 0, 1, 0, 0, 0);
    idle(6);
    // taken branch
    step(0, 0, 0, 1, 1, 0, 0, 0);
    idle(6);
    // memory ready after 3 cycles, StallF raised during the wait
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    idle(6);
    // timeout
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 0);
    idle(6);
    // reset during the memory wait
    repeat (2) step(0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 1, 0, 0);
    idle(10);
    // flush and stall on D together, then a counter clear
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 2);
    end
    idle(2);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
